// File: rtl/fixed_mul_pipe_pkg.sv
// fixed_mul_pipe_pkg
//   Shared definitions for the fixed-point multiplier family.
//   Holds the rounding-mode encodings, the default Q4.28 format and a few
//   Q4.28 constants that datapath users and benches refer to.
package fixed_mul_pipe_pkg;

  // Rounding-mode encodings used by the RND_MODE parameter
  localparam int RND_TRUNC   = 0;  // floor (arithmetic shift)
  localparam int RND_HALF_UP = 1;  // add half an LSB, then floor
  localparam int RND_CONV    = 2;  // half-to-even on exact ties

  // Default Q4.28 format
  localparam int DEF_WIDTH = 32;
  localparam int DEF_FRAC  = 28;

  // Q4.28 constants
  localparam logic [31:0] Q_ONE  = 32'h1000_0000;
  localparam logic [31:0] Q_MAXV = 32'h7FFF_FFFF;
  localparam logic [31:0] Q_MINV = 32'h8000_0000;

endpackage

// File: rtl/fixed_round_sat.sv
// fixed_round_sat
//   Combinational rounding and range reduction of a full-width signed
//   product back to the WIDTH-bit Q format with FRAC fractional bits.
// Ports
//   prod    in   2*WIDTH  full signed product
//   ovf     out  1        rounded value outside the WIDTH-bit signed range
//   result  out  WIDTH    rounded value, clamped (SAT=1) or wrapped (SAT=0)
module fixed_round_sat
  import fixed_mul_pipe_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int FRAC     = DEF_FRAC,
  parameter int RND_MODE = RND_HALF_UP,
  parameter int SAT      = 1
) (
  input  logic [2*WIDTH-1:0] prod,
  output logic               ovf,
  output logic [WIDTH-1:0]   result
);

  // One extra bit over the shifted product so the rounding carry survives
  localparam int RW = 2*WIDTH - FRAC + 1;

  localparam logic [FRAC-1:0]  LSB_ONE  = FRAC'(1'b1);
  localparam logic [FRAC-1:0]  HALF_PAT = LSB_ONE << (FRAC - 1);
  localparam logic [WIDTH-1:0] MAX_VAL  = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam bit               SAT_ON   = (SAT != 32'sd0);

  logic [RW-1:0]       q;
  logic [RW-1:0]       rnd;
  logic [FRAC-1:0]     low;
  logic [RW-WIDTH:0]   top_bits;
  logic                half;
  logic                tie;
  logic                up;
  logic                in_range;

  // Floor of P / 2^FRAC, sign-extended by one bit
  assign q    = {prod[2*WIDTH-1], prod[2*WIDTH-1:FRAC]};
  assign low  = prod[FRAC-1:0];
  assign half = low[FRAC-1];
  assign tie  = (low == HALF_PAT);

  // Round-up decision: adding 2^(FRAC-1) before the shift carries into q
  // exactly when the half bit is set; convergent mode skips that carry on
  // an exact tie with an even q.
  always_comb begin
    up = 1'b0;
    case (RND_MODE)
      RND_TRUNC:   up = 1'b0;
      RND_HALF_UP: up = half;
      RND_CONV:    up = half & ~(tie & ~q[0]);
      default:     up = 1'b0;
    endcase
  end

  assign rnd      = q + {{(RW-1){1'b0}}, up};
  // In range when every bit from the result sign upward agrees
  assign top_bits = rnd[RW-1:WIDTH-1];
  assign in_range = (&top_bits) | ~(|top_bits);
  assign ovf      = ~in_range;

  // Clamp toward the sign of the rounded value, or keep the low bits
  always_comb begin
    result = rnd[WIDTH-1:0];
    if (!in_range && SAT_ON) begin
      result = rnd[RW-1] ? MIN_VAL : MAX_VAL;
    end else begin
      result = rnd[WIDTH-1:0];
    end
  end

endmodule

// File: rtl/fixed_mul_pipe.sv
// fixed_mul_pipe
//   Pipelined signed fixed-point multiplier with rounding, saturation,
//   overflow flag, sideband tag and valid/ready flow control. The whole
//   pipeline stalls together whenever a result is waiting unconsumed.
// Ports
//   clk, rst_n        clock, async active-low reset
//   in_valid/in_ready input handshake;  a, b operands;  in_tag sideband
//   out_valid/out_ready output handshake; result, out_tag, ovf
module fixed_mul_pipe
  import fixed_mul_pipe_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int FRAC     = DEF_FRAC,
  parameter int STAGES   = 3,
  parameter int RND_MODE = RND_HALF_UP,
  parameter int SAT      = 1,
  parameter int TAG_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [TAG_W-1:0] out_tag,
  output logic             ovf
);

  // Full signed product; operands are sign-extended so the low 2*WIDTH
  // bits of the wide multiply are the exact product.
  function automatic logic [2*WIDTH-1:0] mul_full(input logic signed [WIDTH-1:0] x,
                                                  input logic signed [WIDTH-1:0] y);
    logic signed [2*WIDTH-1:0] xe;
    logic signed [2*WIDTH-1:0] ye;
    xe = (2*WIDTH)'(x);
    ye = (2*WIDTH)'(y);
    return xe * ye;
  endfunction

  logic                advance;
  logic                s1_valid;
  logic [WIDTH-1:0]    s1_a;
  logic [WIDTH-1:0]    s1_b;
  logic [TAG_W-1:0]    s1_tag;
  logic                s2_valid;
  logic [2*WIDTH-1:0]  s2_prod;
  logic [TAG_W-1:0]    s2_tag;
  logic [WIDTH-1:0]    rs_result;
  logic                rs_ovf;

  // Global stall: nothing moves while a result sits unaccepted
  assign advance  = ~out_valid | out_ready;
  assign in_ready = advance;

  // Stage 1: capture operands and tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_tag   <= '0;
    end else if (advance) begin
      s1_valid <= in_valid;
      s1_a     <= a;
      s1_b     <= b;
      s1_tag   <= in_tag;
    end
  end

  // Stage 2: register the full-width product
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_prod  <= '0;
      s2_tag   <= '0;
    end else if (advance) begin
      s2_valid <= s1_valid;
      s2_prod  <= mul_full(s1_a, s1_b);
      s2_tag   <= s1_tag;
    end
  end

  fixed_round_sat #(
    .WIDTH    (WIDTH),
    .FRAC     (FRAC),
    .RND_MODE (RND_MODE),
    .SAT      (SAT)
  ) u_round (
    .prod   (s2_prod),
    .ovf    (rs_ovf),
    .result (rs_result)
  );

  // Delay-only stages carrying the already rounded result
  for (genvar k = 0; k < STAGES - 2; k++) begin : g_dly
    logic             v_in;
    logic             ovf_in;
    logic [WIDTH-1:0] res_in;
    logic [TAG_W-1:0] tag_in;
    logic             v_q;
    logic             ovf_q;
    logic [WIDTH-1:0] res_q;
    logic [TAG_W-1:0] tag_q;

    if (k == 0) begin : g_src_round
      assign v_in   = s2_valid;
      assign ovf_in = rs_ovf;
      assign res_in = rs_result;
      assign tag_in = s2_tag;
    end else begin : g_src_prev
      assign v_in   = g_dly[k-1].v_q;
      assign ovf_in = g_dly[k-1].ovf_q;
      assign res_in = g_dly[k-1].res_q;
      assign tag_in = g_dly[k-1].tag_q;
    end

    // Delay register for this stage
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        ovf_q <= 1'b0;
        res_q <= '0;
        tag_q <= '0;
      end else if (advance) begin
        v_q   <= v_in;
        ovf_q <= ovf_in;
        res_q <= res_in;
        tag_q <= tag_in;
      end
    end
  end

  // With only two stages the rounding logic drives the outputs directly
  if (STAGES == 2) begin : g_out_direct
    assign out_valid = s2_valid;
    assign result    = rs_result;
    assign ovf       = rs_ovf;
    assign out_tag   = s2_tag;
  end else begin : g_out_delayed
    assign out_valid = g_dly[STAGES-3].v_q;
    assign result    = g_dly[STAGES-3].res_q;
    assign ovf       = g_dly[STAGES-3].ovf_q;
    assign out_tag   = g_dly[STAGES-3].tag_q;
  end

endmodule

// File: tb/tb_fixed_mul_pipe.sv
// tb_fixed_mul_pipe
//   Three multiplier instances share the input stream: index 0 is
//   STAGES=3/half-up/saturating, index 1 is STAGES=2/truncate/wrapping,
//   index 2 is STAGES=6/convergent/saturating. Expected values come from a
//   plain-arithmetic reference model of the Q4.28 rules.
module tb_fixed_mul_pipe;
  import fixed_mul_pipe_pkg::*;

  localparam int ST   [3] = '{3, 2, 6};
  localparam int RM   [3] = '{RND_HALF_UP, RND_TRUNC, RND_CONV};
  localparam int SATV [3] = '{1, 0, 1};

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [7:0]  in_tag;
  logic        ir    [3];
  logic        ov    [3];
  logic [31:0] res   [3];
  logic [7:0]  otag  [3];
  logic        ovf_o [3];

  int passes = 0;
  int total  = 0;
  logic [31:0] cap_res [3];
  logic        cap_ovf [3];

  fixed_mul_pipe #(.STAGES(ST[0]), .RND_MODE(RM[0]), .SAT(SATV[0])) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[0]), .a(a), .b(b),
    .in_tag(in_tag), .out_valid(ov[0]), .out_ready(out_ready), .result(res[0]),
    .out_tag(otag[0]), .ovf(ovf_o[0]));

  fixed_mul_pipe #(.STAGES(ST[1]), .RND_MODE(RM[1]), .SAT(SATV[1])) dut_s2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[1]), .a(a), .b(b),
    .in_tag(in_tag), .out_valid(ov[1]), .out_ready(out_ready), .result(res[1]),
    .out_tag(otag[1]), .ovf(ovf_o[1]));

  fixed_mul_pipe #(.STAGES(ST[2]), .RND_MODE(RM[2]), .SAT(SATV[2])) dut_s6 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir[2]), .a(a), .b(b),
    .in_tag(in_tag), .out_valid(ov[2]), .out_ready(out_ready), .result(res[2]),
    .out_tag(otag[2]), .ovf(ovf_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference: exact product, floor by 2^28, then the mode's rounding rule
  // applied to the remainder, then range check. Returns {ovf, result}.
  function automatic logic [32:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input int mode, input int sat);
    longint p, q, rem, r;
    logic [31:0] rv;
    logic        o;
    p   = longint'($signed(x)) * longint'($signed(y));
    q   = p >>> 28;
    rem = p - q * 64'sd268435456;
    r   = q;
    if (mode == RND_HALF_UP && rem >= 64'sd134217728) r = q + 64'sd1;
    else if (mode == RND_CONV && (rem > 64'sd134217728 ||
             (rem == 64'sd134217728 && q[0]))) r = q + 64'sd1;
    o  = (r > 64'sd2147483647) || (r < -64'sd2147483648);
    rv = r[31:0];
    if (o && sat != 0) rv = (r < 64'sd0) ? Q_MINV : Q_MAXV;
    return {o, rv};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic signed [31:0] v;
    v = $urandom;
    return v >>> $urandom_range(0, 6);
  endfunction

  // One isolated op: accept on the first edge, then watch every instance
  // until its latency elapses. Called and returns at a negedge.
  task automatic op(input logic [31:0] x, input logic [31:0] y, input logic [7:0] t);
    logic [32:0] m;
    check("op_in_ready", ir[0], 1'b1);
    a = x; b = y; in_tag = t; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) begin @(posedge clk); @(negedge clk); end
      for (int i = 0; i < 3; i++) begin
        if (k < ST[i]) begin
          check("early_valid", ov[i], 1'b0);
        end else if (k == ST[i]) begin
          m = model(x, y, RM[i], SATV[i]);
          check("lat_valid", ov[i], 1'b1);
          check("op_result", res[i], m[31:0]);
          check("op_ovf", ovf_o[i], m[32]);
          check("op_tag", otag[i], t);
          cap_res[i] = res[i];
          cap_ovf[i] = ovf_o[i];
        end
      end
    end
    @(posedge clk); @(negedge clk);
  endtask

  initial begin
    int sent, got, cyc;
    logic acc_prev, stall_prev, povf;
    logic [31:0] pres;
    logic [7:0]  ptag;
    logic [32:0] m;
    logic [32:0] eq [$];
    logic [7:0]  tq [$];
    logic [31:0] ta [100];
    logic [31:0] tb [100];
    int n [3];
    int last_e [3];

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = 32'h0; b = 32'h0; in_tag = 8'h0;
    repeat (3) @(negedge clk);
    check("rst_valid", ov[0], 1'b0);
    check("rst_result", res[0], 32'h0);
    check("rst_tag", otag[0], 8'h0);
    check("rst_ovf", ovf_o[0], 1'b0);
    rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rst_in_ready", ir[0], 1'b1);

    // Basics
    op(Q_ONE, Q_ONE, 8'h01);
    for (int i = 0; i < 3; i++) check("one_sq", {cap_ovf[i], cap_res[i]}, {1'b0, 32'h1000_0000});
    op(32'hE800_0000, 32'hE800_0000, 8'h02);
    for (int i = 0; i < 3; i++) check("m15_sq", {cap_ovf[i], cap_res[i]}, {1'b0, 32'h2400_0000});
    op(32'hF000_0000, Q_ONE, 8'h03);
    for (int i = 0; i < 3; i++) check("m1_x_1", {cap_ovf[i], cap_res[i]}, {1'b0, 32'hF000_0000});

    // Rounding with b = 0.5; index order is half-up / trunc / convergent
    op(32'h1, 32'h0800_0000, 8'h04);
    check("rnd1_hu", cap_res[0], 32'h1);
    check("rnd1_tr", cap_res[1], 32'h0);
    check("rnd1_cv", cap_res[2], 32'h0);
    op(32'h3, 32'h0800_0000, 8'h05);
    check("rnd3_hu", cap_res[0], 32'h2);
    check("rnd3_tr", cap_res[1], 32'h1);
    check("rnd3_cv", cap_res[2], 32'h2);
    op(32'hFFFF_FFFF, 32'h0800_0000, 8'h06);
    check("rndm1_hu", cap_res[0], 32'h0);
    check("rndm1_tr", cap_res[1], 32'hFFFF_FFFF);
    check("rndm1_cv", cap_res[2], 32'h0);

    // Overflow
    op(32'h4000_0000, 32'h4000_0000, 8'h07);
    check("ovf4_sat", {cap_ovf[0], cap_res[0]}, {1'b1, 32'h7FFF_FFFF});
    check("ovf4_wrap", {cap_ovf[1], cap_res[1]}, {1'b1, 32'h0000_0000});
    check("ovf4_sat6", {cap_ovf[2], cap_res[2]}, {1'b1, 32'h7FFF_FFFF});
    op(32'h8000_0000, 32'hF000_0000, 8'h08);
    check("ovf_m8", {cap_ovf[0], cap_res[0]}, {1'b1, 32'h7FFF_FFFF});

    // Backpressure on instance 0: 16 back-to-back ops, random out_ready
    sent = 0; got = 0; cyc = 0; acc_prev = 1'b0; stall_prev = 1'b0;
    pres = 32'h0; ptag = 8'h0; povf = 1'b0;
    while (got < 16 && cyc < 400) begin
      if (stall_prev) begin
        check("stall_valid", ov[0], 1'b1);
        check("stall_result", res[0], pres);
        check("stall_tag", otag[0], ptag);
        check("stall_ovf", ovf_o[0], povf);
      end
      out_ready = 1'($urandom_range(0, 1));
      if (!in_valid || acc_prev) begin
        if (sent < 16) begin
          a = rnd_op(); b = rnd_op(); in_tag = 8'(sent); in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      #1;
      check("in_ready_rule", ir[0], !(ov[0] && !out_ready));
      acc_prev = in_valid && ir[0];
      if (acc_prev) begin
        eq.push_back(model(a, b, RM[0], SATV[0]));
        tq.push_back(in_tag);
        sent++;
      end
      if (ov[0] && out_ready) begin
        check("bp_expected_out", eq.size() != 0, 1'b1);
        if (eq.size() != 0) begin
          m = eq.pop_front();
          check("bp_result", {ovf_o[0], res[0]}, m);
          check("bp_tag", otag[0], tq.pop_front());
        end
        got++;
      end
      stall_prev = ov[0] && !out_ready;
      pres = res[0]; ptag = otag[0]; povf = ovf_o[0];
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    check("bp_count", got, 16);
    check("bp_drained", ov[0], 1'b0);

    // Reset with three ops in flight (held by out_ready = 0)
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a = rnd_op(); b = rnd_op(); in_tag = 8'(8'hA0 + k); in_valid = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0;
    check("full_before_rst", ov[0], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", ov[0], 1'b0);
    check("arst_result", res[0], 32'h0);
    check("arst_tag", otag[0], 8'h0);
    check("arst_ovf", ovf_o[0], 1'b0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check("post_rst_ready", ir[0], 1'b1);
    for (int i = 0; i < 3; i++) check("post_rst_empty", ov[i], 1'b0);
    op(32'h1800_0000, 32'h2000_0000, 8'h5A);
    check("post_rst_op", cap_res[0], 32'h3000_0000);

    // Throughput: continuous stream of 100 random ops
    for (int i = 0; i < 3; i++) begin n[i] = 0; last_e[i] = 0; end
    for (int e = 1; e <= 106; e++) begin
      if (e <= 100) begin
        ta[e-1] = rnd_op(); tb[e-1] = rnd_op();
        a = ta[e-1]; b = tb[e-1]; in_tag = 8'(e - 1); in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (ov[i] && n[i] < 100) begin
          m = model(ta[n[i]], tb[n[i]], RM[i], SATV[i]);
          check("tp_result", {ovf_o[i], res[i]}, m);
          check("tp_tag", otag[i], 8'(n[i]));
          n[i]++;
          last_e[i] = e;
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      check("tp_count", n[i], 100);
      check("tp_last_edge", last_e[i], 99 + ST[i]);
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
